// File: rtl/vm_vend_ctrl.sv
// Vending transaction sequencer: coin credit, one-hot selection check, stock table, change and session timeout.
// Latency: ok sampled in CREDIT -> vend_pulse 2 cycles later -> change valid 3 cycles after ok; all outputs registered.
// No backpressure: inputs are single-cycle pulses; coins arriving while busy or at saturation are flagged via coin_reject.
module vm_vend_ctrl #(
    parameter int NUM_ITEMS   = 8,
    parameter int CREDIT_MAX  = 99,
    parameter int TIMEOUT_CYC = 50_000_000,
    parameter int STOCK_INIT  = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   coin,
    input  logic [NUM_ITEMS-1:0]   choice,
    input  logic                   ok,
    input  logic                   cancel,
    input  logic                   restock,
    input  logic [4*NUM_ITEMS-1:0] item_price,
    output logic [6:0]             credit,
    output logic [6:0]             consume,
    output logic [6:0]             change,
    output logic [NUM_ITEMS-1:0]   stock_led,
    output logic                   vend_pulse,
    output logic [2:0]             vend_item,
    output logic                   coin_reject,
    output logic                   err,
    output logic                   busy
);

    // Timeout counter only needs to reach TIMEOUT_CYC-1.
    localparam int              TW       = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [6:0]      CMAX     = 7'(CREDIT_MAX);
    localparam logic [2:0]      SINIT    = 3'(STOCK_INIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_CHECK,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t                        state_q, state_d;
    logic [6:0]                    credit_q, credit_d;
    logic [6:0]                    consume_q, consume_d;
    logic [6:0]                    change_q, change_d;
    logic [NUM_ITEMS-1:0][2:0]     stock_q, stock_d;
    logic [NUM_ITEMS-1:0]          stock_led_q, stock_led_d;
    logic                          vend_pulse_q, vend_pulse_d;
    logic [2:0]                    vend_item_q, vend_item_d;
    logic                          coin_reject_q, coin_reject_d;
    logic                          err_q, err_d;
    logic                          busy_q, busy_d;
    logic [TW-1:0]                 tmo_q, tmo_d;
    logic [NUM_ITEMS-1:0]          sel_q, sel_d;
    logic [2:0]                    idx_q, idx_d;
    logic [3:0]                    price_q, price_d;

    logic [2:0]                    sel_idx;
    logic [3:0]                    sel_price;

    // Encode the selection (lowest set bit) and look up its price; one-hotness is judged later in CHECK.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
            if (choice[i]) begin
                sel_idx = 3'(i);
            end
        end
        sel_price = item_price[4*int'(sel_idx) +: 4];
    end

    // Next-state and next-output logic for the transaction FSM and the stock table.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        consume_d     = consume_q;
        change_d      = change_q;
        stock_d       = stock_q;
        vend_pulse_d  = 1'b0;
        vend_item_d   = vend_item_q;
        coin_reject_d = 1'b0;
        err_d         = 1'b0;
        tmo_d         = tmo_q;
        sel_d         = sel_q;
        idx_d         = idx_q;
        price_d       = price_q;

        case (state_q)
            S_IDLE: begin
                if (coin) begin
                    credit_d  = 7'd1;
                    consume_d = 7'd0;
                    change_d  = 7'd0;
                    tmo_d     = '0;
                    state_d   = S_CREDIT;
                end
                if (restock) begin
                    for (int i = 0; i < NUM_ITEMS; i++) begin
                        stock_d[i] = SINIT;
                    end
                end
            end
            S_CREDIT: begin
                if (coin) begin
                    // A coin always restarts the idle window, even when it cannot be accepted.
                    tmo_d = '0;
                    if (credit_q < CMAX) begin
                        credit_d = credit_q + 7'd1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (cancel) begin
                    state_d = S_CHANGE;
                end else if (ok) begin
                    sel_d   = choice;
                    idx_d   = sel_idx;
                    price_d = sel_price;
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    state_d = S_CHANGE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (!$onehot(sel_q) || (price_q == 4'd0) || (stock_q[idx_q] == 3'd0) ||
                    ({3'b000, price_q} > credit_q)) begin
                    err_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = S_CREDIT;
                end else begin
                    state_d = S_DISPENSE;
                end
            end
            S_DISPENSE: begin
                vend_pulse_d    = 1'b1;
                vend_item_d     = idx_q;
                stock_d[idx_q]  = stock_q[idx_q] - 3'd1;
                credit_d        = credit_q - {3'b000, price_q};
                consume_d       = {3'b000, price_q};
                state_d         = S_CHANGE;
            end
            S_CHANGE: begin
                change_d = credit_q;
                credit_d = 7'd0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy_q mirrors CHECK/DISPENSE/CHANGE, so it doubles as the "coin not accepted" window.
        if (coin && busy_q) begin
            coin_reject_d = 1'b1;
        end

        busy_d = (state_d == S_CHECK) || (state_d == S_DISPENSE) || (state_d == S_CHANGE);
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_led_d[i] = (stock_d[i] != 3'd0);
        end
    end

    // State and registered outputs; reset drops any pending credit without a refund.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= 7'd0;
            consume_q     <= 7'd0;
            change_q      <= 7'd0;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= SINIT;
            end
            stock_led_q   <= {NUM_ITEMS{SINIT != 3'd0}};
            vend_pulse_q  <= 1'b0;
            vend_item_q   <= 3'd0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            tmo_q         <= '0;
            sel_q         <= '0;
            idx_q         <= 3'd0;
            price_q       <= 4'd0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            consume_q     <= consume_d;
            change_q      <= change_d;
            stock_q       <= stock_d;
            stock_led_q   <= stock_led_d;
            vend_pulse_q  <= vend_pulse_d;
            vend_item_q   <= vend_item_d;
            coin_reject_q <= coin_reject_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            tmo_q         <= tmo_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            price_q       <= price_d;
        end
    end

    assign credit      = credit_q;
    assign consume     = consume_q;
    assign change      = change_q;
    assign stock_led   = stock_led_q;
    assign vend_pulse  = vend_pulse_q;
    assign vend_item   = vend_item_q;
    assign coin_reject = coin_reject_q;
    assign err         = err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vm_vend_ctrl.sv
// Scoreboard bench for vm_vend_ctrl: expected vend/err/reject/change events queued at stimulus time.
// Latency of vend and timeout refund is checked against a free-running cycle counter.
// Inputs driven 1 time unit after the rising edge; outputs sampled on the falling edge.
module tb_vm_vend_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coin = 1'b0;
    logic [7:0]  choice = 8'd0;
    logic        ok = 1'b0;
    logic        cancel = 1'b0;
    logic        restock = 1'b0;
    logic [31:0] item_price;
    logic [6:0]  credit, consume, change;
    logic [7:0]  stock_led;
    logic        vend_pulse, coin_reject, err, busy;
    logic [2:0]  vend_item;

    vm_vend_ctrl #(
        .NUM_ITEMS   (8),
        .CREDIT_MAX  (99),
        .TIMEOUT_CYC (16),
        .STOCK_INIT  (7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin        (coin),
        .choice      (choice),
        .ok          (ok),
        .cancel      (cancel),
        .restock     (restock),
        .item_price  (item_price),
        .credit      (credit),
        .consume     (consume),
        .change      (change),
        .stock_led   (stock_led),
        .vend_pulse  (vend_pulse),
        .vend_item   (vend_item),
        .coin_reject (coin_reject),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int item; int price; int credit; int cyc;} vexp_t;
    typedef struct {int val; int cyc;} cexp_t;

    vexp_t vq[$];
    cexp_t cq[$];
    int    eq[$];
    int    rq[$];

    int n_chk = 0;
    int n_err = 0;

    int m_price[8];
    int m_stock[8];
    int m_credit = 0;
    bit m_act = 0;
    int last_coin_cyc = 0;
    bit mon_en = 0;
    bit busy_prev = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int exp_led();
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_stock[i] != 0) r |= (1 << i);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Event monitor: every output event must match the head of its queue.
    always @(negedge clk) begin
        vexp_t v;
        cexp_t c;
        int    e;
        if (mon_en && !rst) begin
            if (vend_pulse) begin
                if (vq.size() == 0) chk("vend_unexpected", 1, 0);
                else begin
                    v = vq.pop_front();
                    chk("vend_item", int'(vend_item), v.item);
                    chk("vend_consume", int'(consume), v.price);
                    chk("vend_credit", int'(credit), v.credit);
                    chk("vend_latency", cyc, v.cyc);
                end
            end
            if (err) begin
                if (eq.size() == 0) chk("err_unexpected", 1, 0);
                else begin
                    e = eq.pop_front();
                    chk("err_credit", int'(credit), e);
                end
            end
            if (coin_reject) begin
                if (rq.size() == 0) chk("reject_unexpected", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("reject_credit", int'(credit), e);
                end
            end
            if (busy_prev && !busy && !err) begin
                if (cq.size() == 0) chk("change_unexpected", 1, 0);
                else begin
                    c = cq.pop_front();
                    chk("change_val", int'(change), c.val);
                    chk("change_credit0", int'(credit), 0);
                    if (c.cyc >= 0) chk("change_latency", cyc, c.cyc);
                end
            end
        end
        busy_prev = busy;
    end

    task automatic do_coin();
        if (!m_act) begin
            m_act    = 1;
            m_credit = 1;
        end else if (m_credit < 99) begin
            m_credit++;
        end else begin
            rq.push_back(m_credit);
        end
        coin = 1'b1;
        last_coin_cyc = cyc;
        step();
        coin = 1'b0;
    endtask

    task automatic do_cancel();
        cexp_t c;
        c.val = m_credit;
        c.cyc = -1;
        cq.push_back(c);
        m_act    = 0;
        m_credit = 0;
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        repeat (3) step();
    endtask

    task automatic do_buy(input logic [7:0] ch, input bit coin_mid);
        int    idx = 0;
        bit    good;
        vexp_t v;
        cexp_t c;
        for (int i = 7; i >= 0; i--) if (ch[i]) idx = i;
        good = ($countones(ch) == 1) && (m_price[idx] != 0) && (m_stock[idx] != 0) &&
               (m_price[idx] <= m_credit);
        choice = ch;
        ok     = 1'b1;
        if (good) begin
            v.item   = idx;
            v.price  = m_price[idx];
            v.credit = m_credit - m_price[idx];
            v.cyc    = cyc + 3;
            vq.push_back(v);
            c.val = m_credit - m_price[idx];
            c.cyc = -1;
            cq.push_back(c);
        end else begin
            eq.push_back(m_credit);
        end
        step();
        ok = 1'b0;
        if (good) begin
            if (coin_mid) begin
                rq.push_back(m_credit);
                coin = 1'b1;
                step();
                coin = 1'b0;
                repeat (3) step();
            end else begin
                repeat (4) step();
            end
            m_stock[idx]--;
            m_act    = 0;
            m_credit = 0;
        end else begin
            repeat (2) step();
        end
    endtask

    initial begin
        cexp_t c;
        m_price = '{1, 5, 2, 3, 0, 4, 4, 4};
        for (int i = 0; i < 8; i++) begin
            m_stock[i] = 7;
            item_price[4*i +: 4] = 4'(m_price[i]);
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #3;
        chk("rst_credit", int'(credit), 0);
        chk("rst_consume", int'(consume), 0);
        chk("rst_change", int'(change), 0);
        chk("rst_stock_led", int'(stock_led), 255);
        chk("rst_vend_pulse", int'(vend_pulse), 0);
        chk("rst_vend_item", int'(vend_item), 0);
        chk("rst_err_rej_busy", int'({err, coin_reject, busy}), 0);
        step();
        mon_en = 1;

        // Basic purchase: 3 coins, item 2 at price 2.
        repeat (3) do_coin();
        chk("t1_credit3", int'(credit), 3);
        do_buy(8'b0000_0100, 0);
        chk("t1_consume", int'(consume), 2);
        chk("t1_change", int'(change), 1);
        chk("t1_credit", int'(credit), 0);

        // Insufficient funds, then refund.
        do_coin();
        do_buy(8'b0000_1000, 0);
        chk("t2_credit", int'(credit), 1);
        chk("t2_busy", int'(busy), 0);
        do_cancel();

        // Drain item 0, then an attempt on the empty slot.
        for (int k = 0; k < 7; k++) begin
            do_coin();
            do_buy(8'b0000_0001, 0);
        end
        chk("t3_led", int'(stock_led), exp_led());
        do_coin();
        do_buy(8'b0000_0001, 0);
        chk("t3_credit", int'(credit), 1);
        do_cancel();

        // Bad selections: two-hot, none, price 0; then cancel.
        do_coin();
        do_coin();
        do_buy(8'b0000_0011, 0);
        do_buy(8'b0000_0000, 0);
        do_buy(8'b0001_0000, 0);
        do_buy(8'b0000_0010, 0);
        chk("t4_credit", int'(credit), 2);
        do_cancel();
        chk("t4_consume", int'(consume), 0);

        // Coin during CHECK is rejected and does not alter the purchase.
        repeat (3) do_coin();
        do_buy(8'b0000_0100, 1);
        chk("t5_change", int'(change), 1);

        // Saturation at 99, 100th coin rejected.
        repeat (100) do_coin();
        chk("t6_credit99", int'(credit), 99);
        do_cancel();

        // Coin and ok together: coin counted, no check.
        repeat (3) do_coin();
        choice = 8'b0000_0100;
        ok = 1'b1;
        do_coin();
        ok = 1'b0;
        step();
        chk("t7_busy", int'(busy), 0);
        chk("t7_credit", int'(credit), 4);
        do_cancel();

        // Restock ignored in CREDIT, honoured in IDLE.
        do_coin();
        restock = 1'b1;
        step();
        restock = 1'b0;
        step();
        chk("t8_restock_ignored", int'(stock_led), exp_led());
        do_cancel();
        restock = 1'b1;
        step();
        restock = 1'b0;
        step();
        for (int i = 0; i < 8; i++) m_stock[i] = 7;
        chk("t8_restock_idle", int'(stock_led), 255);

        // Timeout auto-refund after 16 idle cycles.
        do_coin();
        do_coin();
        c.val = 2;
        c.cyc = last_coin_cyc + 18;
        cq.push_back(c);
        m_act = 0;
        m_credit = 0;
        repeat (30) step();

        chk("left_vend", vq.size(), 0);
        chk("left_change", cq.size(), 0);
        chk("left_err", eq.size(), 0);
        chk("left_reject", rq.size(), 0);

        // Asynchronous reset while dispensing.
        mon_en = 0;
        repeat (5) do_coin();
        choice = 8'b0000_0010;
        ok = 1'b1;
        step();
        ok = 1'b0;
        step();
        chk("t9_in_dispense", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t9_credit", int'(credit), 0);
        chk("t9_consume", int'(consume), 0);
        chk("t9_change", int'(change), 0);
        chk("t9_vend_item", int'(vend_item), 0);
        chk("t9_pulses_busy", int'({vend_pulse, err, coin_reject, busy}), 0);
        chk("t9_stock_led", int'(stock_led), 255);
        repeat (2) @(posedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
